// File: rtl/ft245_responder_pkg.sv
// ft245_responder_pkg
//   Shared definitions for the FT245-style responder: the byte width,
//   the read/write strobe FSM state encodings, and a helper that sizes
//   the precharge counters.
package ft245_responder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACTIVE = 2'd1,
    R_PRE    = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_PRE    = 2'd2
  } wr_state_e;

  // The counter is loaded with PRECHARGE-1 and counts down to zero.
  function automatic int pre_cnt_w(input int pre);
    return (pre > 1) ? $clog2(pre) : 1;
  endfunction

endpackage

// File: rtl/ft245_responder_byte_fifo.sv
// ft245_responder_byte_fifo
//   Synchronous byte FIFO, DEPTH entries (power of two, >= 2).
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   Ports:
//     clk, reset     clock, synchronous active-high reset (pointers only)
//     push, wdata    write request and byte; ignored when full
//     pop            read request; ignored when empty
//     rdata          head entry, combinational from the storage array
//     full, empty    occupancy flags for the current cycle
//     count          number of stored entries (0..DEPTH)
module ft245_responder_byte_fifo
  import ft245_responder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [BYTE_W-1:0]       wdata,
  input  logic                    pop,
  output logic [BYTE_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [BYTE_W-1:0]  mem [DEPTH];
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/ft245_responder.sv
// ft245_responder
//   Device-side model of an FT245-style asynchronous byte FIFO interface.
//   The SoC reads bytes with active-low ft_rd_n and writes with ft_wr_n;
//   the responder answers with registered ft_rdata/ft_oe and the
//   ft_rxf_n/ft_txe_n availability flags. Bytes for the SoC arrive on the
//   host_in valid/ready stream (RX FIFO); bytes the SoC writes leave on the
//   host_out valid/ready stream (TX FIFO).
//   Ports:
//     clk, reset                 single clock, synchronous active-high reset
//     ft_rd_n, ft_wr_n           SoC strobes, active low, synchronous to clk
//     ft_wdata                   byte written by the SoC
//     ft_rdata, ft_oe            byte returned to the SoC, bus drive enable
//     ft_rxf_n, ft_txe_n         0 = byte available / space available
//     host_in_*                  byte stream into the RX FIFO
//     host_out_*                 byte stream out of the TX FIFO
//     proto_err                  sticky protocol-violation flag
module ft245_responder
  import ft245_responder_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PRECHARGE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ft_rd_n,
  input  logic              ft_wr_n,
  input  logic [BYTE_W-1:0] ft_wdata,
  output logic [BYTE_W-1:0] ft_rdata,
  output logic              ft_oe,
  output logic              ft_rxf_n,
  output logic              ft_txe_n,
  input  logic [BYTE_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [BYTE_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic              proto_err
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             PCW      = pre_cnt_w(PRECHARGE);
  localparam logic [PCW-1:0] PRE_LOAD = PCW'(PRECHARGE - 1);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  // ---- strobe edge detection against the previous sampled level ----
  // The history resets to "low" so a strobe still held low when reset
  // releases is not seen as a fresh falling edge; it must rise first.
  logic rd_n_p1;
  logic wr_n_p1;
  logic rd_fall;
  logic rd_rise;
  logic wr_fall;
  logic wr_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_n_p1 <= 1'b0;
      wr_n_p1 <= 1'b0;
    end else begin
      rd_n_p1 <= ft_rd_n;
      wr_n_p1 <= ft_wr_n;
    end
  end

  assign rd_fall = rd_n_p1 & ~ft_rd_n;
  assign rd_rise = ~rd_n_p1 & ft_rd_n;
  assign wr_fall = wr_n_p1 & ~ft_wr_n;
  assign wr_rise = ~wr_n_p1 & ft_wr_n;

  // ---- byte FIFOs ----
  logic              rx_push;
  logic              rx_pop;
  logic [BYTE_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [AW:0]       rx_count;
  logic [AW:0]       rx_cnt_nxt;

  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [AW:0]       tx_count;
  logic [AW:0]       tx_cnt_nxt;

  assign rx_push = host_in_valid & host_in_ready & ~rx_full;
  assign tx_pop  = host_out_valid & host_out_ready & ~tx_empty;

  ft245_responder_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (host_in_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  ft245_responder_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .wdata (ft_wdata),
    .pop   (tx_pop),
    .rdata (host_out_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // Stream-side flags are registered from the occupancy after this
  // cycle's push/pop, so they are exact for the following cycle and a
  // simultaneous push and pop leaves them unchanged.
  assign rx_cnt_nxt = rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
  assign tx_cnt_nxt = tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      host_in_ready  <= 1'b0;
      host_out_valid <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      host_in_ready  <= (rx_cnt_nxt != FULL_CNT);
      host_out_valid <= (tx_cnt_nxt != '0);
      if ((rd_fall && ft_rxf_n) || (wr_fall && ft_txe_n) || (!ft_rd_n && !ft_wr_n))
        proto_err <= 1'b1;
    end
  end

  // ---- read FSM ----
  rd_state_e         r_state;
  rd_state_e         r_state_nxt;
  logic [PCW-1:0]    rcnt;
  logic [PCW-1:0]    rcnt_nxt;
  logic [BYTE_W-1:0] rdata_nxt;
  logic              oe_nxt;
  logic              rxf_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= R_IDLE;
      rcnt     <= '0;
      ft_rdata <= '0;
      ft_oe    <= 1'b0;
      ft_rxf_n <= 1'b1;
    end else begin
      r_state  <= r_state_nxt;
      rcnt     <= rcnt_nxt;
      ft_rdata <= rdata_nxt;
      ft_oe    <= oe_nxt;
      ft_rxf_n <= rxf_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    rcnt_nxt    = rcnt;
    rdata_nxt   = ft_rdata;
    oe_nxt      = ft_oe;
    rxf_nxt     = ft_rxf_n;
    rx_pop      = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        rxf_nxt = rx_empty;
        if (rd_fall && !ft_rxf_n) begin
          rx_pop      = 1'b1;
          rdata_nxt   = rx_head;
          oe_nxt      = 1'b1;
          rxf_nxt     = 1'b0;
          r_state_nxt = R_ACTIVE;
        end
      end
      R_ACTIVE: begin
        if (rd_rise) begin
          oe_nxt      = 1'b0;
          rxf_nxt     = 1'b1;
          rcnt_nxt    = PRE_LOAD;
          r_state_nxt = R_PRE;
        end
      end
      R_PRE: begin
        if (rcnt == '0) begin
          rxf_nxt     = rx_empty;
          r_state_nxt = R_IDLE;
        end else begin
          rcnt_nxt = rcnt - 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // ---- write FSM ----
  wr_state_e      w_state;
  wr_state_e      w_state_nxt;
  logic [PCW-1:0] wcnt;
  logic [PCW-1:0] wcnt_nxt;
  logic           txe_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state  <= W_IDLE;
      wcnt     <= '0;
      ft_txe_n <= 1'b1;
    end else begin
      w_state  <= w_state_nxt;
      wcnt     <= wcnt_nxt;
      ft_txe_n <= txe_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    wcnt_nxt    = wcnt;
    txe_nxt     = ft_txe_n;
    tx_push     = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        txe_nxt = tx_full;
        if (wr_fall && !ft_txe_n) begin
          tx_push     = 1'b1;
          txe_nxt     = 1'b1;
          w_state_nxt = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        if (wr_rise) begin
          wcnt_nxt    = PRE_LOAD;
          w_state_nxt = W_PRE;
        end
      end
      W_PRE: begin
        if (wcnt == '0) begin
          txe_nxt     = tx_full;
          w_state_nxt = W_IDLE;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft245_responder.sv
module tb_ft245_responder;

  localparam int DEPTH = 16;
  localparam int PRE   = 2;
  localparam int N_RX  = 2 * DEPTH + 3;
  localparam int N_TX  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ft_rd_n = 1'b1;
  logic       ft_wr_n = 1'b1;
  logic [7:0] ft_wdata = 8'h00;
  logic [7:0] ft_rdata;
  logic       ft_oe;
  logic       ft_rxf_n;
  logic       ft_txe_n;
  logic [7:0] host_in_data = 8'h00;
  logic       host_in_valid = 1'b0;
  logic       host_in_ready;
  logic [7:0] host_out_data;
  logic       host_out_valid;
  logic       host_out_ready = 1'b0;
  logic       proto_err;

  int n_cmp = 0;
  int n_err = 0;
  int rx_pushed = 0;
  logic stream_done = 1'b0;

  // Reference model: byte order through each direction is plain FIFO order.
  logic [7:0] rx_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] out_q[$];

  always #5 clk = ~clk;

  ft245_responder #(.DEPTH(DEPTH), .PRECHARGE(PRE)) dut (
    .clk            (clk),
    .reset          (reset),
    .ft_rd_n        (ft_rd_n),
    .ft_wr_n        (ft_wr_n),
    .ft_wdata       (ft_wdata),
    .ft_rdata       (ft_rdata),
    .ft_oe          (ft_oe),
    .ft_rxf_n       (ft_rxf_n),
    .ft_txe_n       (ft_txe_n),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .proto_err      (proto_err)
  );

  // Handshakes are judged mid-cycle; the transfer happens at the next posedge.
  always @(negedge clk) begin
    if (!reset && host_in_valid && host_in_ready) begin
      rx_exp.push_back(host_in_data);
      rx_pushed++;
    end
    if (!reset && host_out_valid && host_out_ready)
      out_q.push_back(host_out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic host_push(input logic [7:0] b);
    int n = 0;
    host_in_data  = b;
    host_in_valid = 1'b1;
    while (!host_in_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", host_in_ready, 1'b1);
    tick();
    host_in_valid = 1'b0;
  endtask

  task automatic wait_txe(input string tag);
    int n = 0;
    while (ft_txe_n && n < 50) begin
      tick();
      n++;
    end
    check(tag, ft_txe_n, 1'b0);
  endtask

  task automatic rd_pulse(input int low, output logic [7:0] dat, output logic oe_on,
                          output logic oe_off, output logic rxf_off);
    ft_rd_n = 1'b0;
    tick();
    oe_on = ft_oe;
    dat   = ft_rdata;
    repeat (low - 1) tick();
    ft_rd_n = 1'b1;
    tick();
    oe_off  = ft_oe;
    rxf_off = ft_rxf_n;
  endtask

  task automatic soc_write(input logic [7:0] b, input int low);
    ft_wdata = b;
    ft_wr_n  = 1'b0;
    tick();
    repeat (low - 1) tick();
    ft_wr_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic o1, o2, r2;

    // Reset values
    do_reset();
    check("rst_rxf_n", ft_rxf_n, 1'b1);
    check("rst_txe_n", ft_txe_n, 1'b1);
    check("rst_oe", ft_oe, 1'b0);
    check("rst_rdata", ft_rdata, 8'h00);
    check("rst_in_ready", host_in_ready, 1'b0);
    check("rst_out_valid", host_out_valid, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    tick();
    check("idle_txe_n", ft_txe_n, 1'b0);
    check("idle_in_ready", host_in_ready, 1'b1);
    check("idle_rxf_n", ft_rxf_n, 1'b1);

    // Two host bytes read back by the SoC
    host_push(8'h41);
    check("t1_rxf_lat_n1", ft_rxf_n, 1'b1);
    tick();
    check("t1_rxf_lat_n2", ft_rxf_n, 1'b0);
    host_push(8'h42);
    rd_pulse(3, d, o1, o2, r2);
    check("t1_rd1_data", d, 8'h41);
    check("t1_rd1_oe_on", o1, 1'b1);
    check("t1_rd1_oe_off", o2, 1'b0);
    check("t1_rd1_rxf_off", r2, 1'b1);
    tick();
    check("t1_rd1_precharge", ft_rxf_n, 1'b1);
    tick();
    check("t1_rd1_rxf_back", ft_rxf_n, 1'b0);
    rd_pulse(3, d, o1, o2, r2);
    check("t1_rd2_data", d, 8'h42);
    check("t1_rd2_oe_on", o1, 1'b1);
    tick();
    tick();
    check("t1_rxf_empty", ft_rxf_n, 1'b1);

    // Single SoC write with the consumer ready
    out_q.delete();
    host_out_ready = 1'b1;
    ft_wdata = 8'h55;
    ft_wr_n  = 1'b0;
    tick();
    check("t2_txe_active", ft_txe_n, 1'b1);
    tick();
    ft_wr_n = 1'b1;
    tick();
    check("t2_txe_pre1", ft_txe_n, 1'b1);
    tick();
    check("t2_txe_pre2", ft_txe_n, 1'b1);
    tick();
    check("t2_txe_back", ft_txe_n, 1'b0);
    check("t2_out_count", out_q.size(), 1);
    check("t2_out_data", out_q[0], 8'h55);

    // Fill TX, overflow write, drain in order
    out_q.delete();
    host_out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wait_txe("t3_txe_free");
      soc_write(8'h80 + 8'(i), 1 + (i % 2));
    end
    repeat (4) tick();
    check("t3_txe_full", ft_txe_n, 1'b1);
    check("t3_out_valid", host_out_valid, 1'b1);
    check("t3_no_err_yet", proto_err, 1'b0);
    ft_wdata = 8'hEE;
    ft_wr_n  = 1'b0;
    tick();
    check("t3_overflow_err", proto_err, 1'b1);
    ft_wr_n = 1'b1;
    tick();
    host_out_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    check("t3_drain_count", out_q.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < out_q.size(); i++)
      check("t3_drain_data", out_q[i], 8'h80 + 8'(i));
    check("t3_txe_after_drain", ft_txe_n, 1'b0);

    // Read from empty RX, then overlapping strobes
    do_reset();
    check("t4_err_cleared", proto_err, 1'b0);
    tick();
    ft_rd_n = 1'b0;
    tick();
    check("t4_empty_rd_oe", ft_oe, 1'b0);
    check("t4_empty_rd_err", proto_err, 1'b1);
    ft_rd_n = 1'b1;
    tick();
    do_reset();
    tick();
    out_q.delete();
    host_out_ready = 1'b1;
    host_push(8'hA5);
    tick();
    check("t4_rxf_ready", ft_rxf_n, 1'b0);
    ft_wdata = 8'h3C;
    ft_rd_n  = 1'b0;
    ft_wr_n  = 1'b0;
    tick();
    check("t4_both_oe", ft_oe, 1'b1);
    check("t4_both_rdata", ft_rdata, 8'hA5);
    check("t4_both_err", proto_err, 1'b1);
    ft_rd_n = 1'b1;
    ft_wr_n = 1'b1;
    repeat (5) tick();
    check("t4_both_wr_count", out_q.size(), 1);
    check("t4_both_wr_data", out_q[0], 8'h3C);
    check("t4_both_rx_empty", ft_rxf_n, 1'b1);

    // Reset in the middle of a read strobe
    do_reset();
    tick();
    host_push(8'h77);
    tick();
    check("t5_rxf_ready", ft_rxf_n, 1'b0);
    ft_rd_n = 1'b0;
    tick();
    check("t5_active_oe", ft_oe, 1'b1);
    check("t5_active_rdata", ft_rdata, 8'h77);
    reset = 1'b1;
    tick();
    check("t5_rst_oe", ft_oe, 1'b0);
    check("t5_rst_rxf", ft_rxf_n, 1'b1);
    reset = 1'b0;
    tick();
    tick();
    check("t5_fifo_empty", ft_rxf_n, 1'b1);
    check("t5_oe_low", ft_oe, 1'b0);
    host_push(8'h99);
    tick();
    tick();
    check("t5_rxf_new", ft_rxf_n, 1'b0);
    check("t5_held_low_no_read", ft_oe, 1'b0);
    check("t5_held_low_no_err", proto_err, 1'b0);
    ft_rd_n = 1'b1;
    tick();
    rd_pulse(2, d, o1, o2, r2);
    check("t5_reread_data", d, 8'h99);
    check("t5_reread_oe", o1, 1'b1);

    // Randomized streaming in both directions with overlapping RX push/pop
    do_reset();
    tick();
    rx_exp.delete();
    tx_exp.delete();
    out_q.delete();
    rx_pushed   = 0;
    stream_done = 1'b0;
    fork
      begin : host_in_driver
        int guard = 0;
        while (rx_pushed < N_RX && guard < 5000) begin
          host_in_valid = ($urandom_range(3, 0) != 0);
          host_in_data  = 8'($urandom);
          tick();
          guard++;
        end
        host_in_valid = 1'b0;
      end
      begin : soc_driver
        int rd_done = 0;
        int wr_done = 0;
        int budget  = 0;
        logic [7:0] rd_b, wb;
        logic a, b, c;
        while ((rd_done < N_RX || wr_done < N_TX) && budget < 20000) begin
          if (rd_done < N_RX && !ft_rxf_n && (wr_done >= N_TX || $urandom_range(1, 0) == 1)) begin
            rd_pulse($urandom_range(3, 1), rd_b, a, b, c);
            check("stream_rd_underflow", (rx_exp.size() > 0), 1'b1);
            if (rx_exp.size() > 0) check("stream_rd_data", rd_b, rx_exp.pop_front());
            rd_done++;
          end else if (wr_done < N_TX && !ft_txe_n) begin
            wb = 8'($urandom);
            tx_exp.push_back(wb);
            soc_write(wb, $urandom_range(3, 1));
            wr_done++;
          end else begin
            tick();
          end
          budget++;
        end
        check("stream_rd_done", rd_done, N_RX);
        check("stream_wr_done", wr_done, N_TX);
        stream_done = 1'b1;
      end
      begin : host_out_driver
        while (!stream_done) begin
          host_out_ready = ($urandom_range(1, 0) == 1);
          tick();
        end
        host_out_ready = 1'b1;
      end
    join
    repeat (DEPTH + 6) tick();
    check("stream_out_count", out_q.size(), N_TX);
    for (int i = 0; i < N_TX && i < out_q.size(); i++)
      check("stream_out_data", out_q[i], tx_exp[i]);
    check("stream_rx_leftover", rx_exp.size(), 0);
    check("stream_no_err", proto_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
